// File: rtl/csr_read_arbiter.sv
// CSR read arbiter: N requesters share one registered response slot.
// Fixed-priority or round-robin grant, address-to-slot lookup, 1-cycle read latency.
module csr_read_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int NUM_CSR        = 8,
    parameter logic [NUM_CSR*CSR_ADDR_WIDTH-1:0] CSR_ADDR_LIST = '0,
    parameter int N_PORTS        = 2,
    parameter int ARB_MODE       = 0,
    localparam int PORT_W        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_CSR*DATA_WIDTH-1:0]     csr_data_i,
    input  logic [N_PORTS-1:0]                req_valid_i,
    input  logic [N_PORTS*CSR_ADDR_WIDTH-1:0] req_addr_i,
    output logic [N_PORTS-1:0]                req_ready_o,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [PORT_W-1:0]                 rsp_port_o,
    output logic [DATA_WIDTH-1:0]             rsp_data_o,
    output logic                              rsp_illegal_o,
    output logic [31:0]                       rd_count_o
);

    logic                      rsp_valid_q, rsp_valid_d;
    logic [PORT_W-1:0]         rsp_port_q, rsp_port_d;
    logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                      rsp_illegal_q, rsp_illegal_d;
    logic [31:0]               rd_count_q, rd_count_d;
    logic [PORT_W-1:0]         rr_ptr_q, rr_ptr_d;

    logic                      slot_free;
    logic [N_PORTS-1:0]        eligible;
    logic                      grant_any;
    logic [PORT_W-1:0]         grant_idx;
    logic [N_PORTS-1:0]        grant_vec;
    logic [CSR_ADDR_WIDTH-1:0] grant_addr;
    logic                      hit;
    logic [DATA_WIDTH-1:0]     hit_data;

    // Reset gates eligibility so nothing is granted while rst_i is low.
    assign slot_free = !rsp_valid_q || rsp_ready_i;
    assign eligible  = req_valid_i & {N_PORTS{rst_i && slot_free}};

    always_comb begin
        logic [PORT_W-1:0] idx;
        int                start;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        idx       = '0;
        start     = (ARB_MODE == 1) ? int'(rr_ptr_q) : 0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = PORT_W'((start + i) % N_PORTS);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign req_ready_o = grant_vec;
    assign grant_addr  = req_addr_i[grant_idx*CSR_ADDR_WIDTH +: CSR_ADDR_WIDTH];

    // Scan from the top so the lowest matching slot overwrites any higher one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = NUM_CSR - 1; k >= 0; k--) begin
            if (grant_addr == CSR_ADDR_LIST[k*CSR_ADDR_WIDTH +: CSR_ADDR_WIDTH]) begin
                hit      = 1'b1;
                hit_data = csr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_port_d    = rsp_port_q;
        rsp_data_d    = rsp_data_q;
        rsp_illegal_d = rsp_illegal_q;
        rd_count_d    = rd_count_q;
        rr_ptr_d      = rr_ptr_q;
        if (grant_any) begin
            rsp_valid_d   = 1'b1;
            rsp_port_d    = grant_idx;
            rsp_data_d    = hit ? hit_data : '0;
            rsp_illegal_d = !hit;
            rd_count_d    = rd_count_q + 32'd1;
            if (ARB_MODE == 1) begin
                rr_ptr_d = PORT_W'((int'(grant_idx) + 1) % N_PORTS);
            end
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_port_q    <= '0;
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
            rd_count_q    <= '0;
            rr_ptr_q      <= '0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_port_q    <= rsp_port_d;
            rsp_data_q    <= rsp_data_d;
            rsp_illegal_q <= rsp_illegal_d;
            rd_count_q    <= rd_count_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_port_o    = rsp_port_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_illegal_o = rsp_illegal_q;
    assign rd_count_o    = rd_count_q;

endmodule
